// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: opcodes, NOP word, branch
// prediction mode codes and the fetch FSM state encoding.
package cpu_pkg;

  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [1:0] BP_NOT_TAKEN = 2'b00;
  localparam logic [1:0] BP_TAKEN     = 2'b01;
  localparam logic [1:0] BP_DELAY     = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_JPEND = 1'b1
  } fetch_state_t;

  // Mode 11 is reserved and behaves exactly like not-taken.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? BP_NOT_TAKEN : m;
  endfunction

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory: IM_DEPTH x 32-bit words, combinational read.
// The array is named memory so benches can preload it hierarchically.
module fetch_imem #(
  parameter int IM_DEPTH = 64,
  parameter int AW       = $clog2(IM_DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);

  logic [31:0] memory [IM_DEPTH];

  assign rdata = memory[addr];

endmodule

// File: rtl/fetch_stage_bp.sv
// Instruction-fetch stage: PC register, instruction memory read, IF/ID
// register, J/BEQ predecode, EX redirect mux and delay-slot jump FSM.
// Optional build macro FETCH_PERF_EN adds saturating performance counters
// perf_fetch, perf_redir and perf_stall.
module fetch_stage_bp
  import cpu_pkg::*;
#(
  parameter int          IM_DEPTH = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  bp_mode,
  input  logic        stall,
  input  logic        ex_br_valid,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic [31:0] ex_br_pc4,
  output logic [31:0] pc,
  output logic [31:0] if_ir,
  output logic [31:0] if_pc4,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_redir,
  output logic [31:0] perf_stall,
`endif
  output logic        id_flush
);

  localparam int AW = $clog2(IM_DEPTH);

  fetch_state_t state, state_nxt;
  logic [31:0] jtgt, jtgt_nxt;
  logic [31:0] pc_nxt, ir_nxt, ifpc4_nxt;

  logic [31:0]        fetch_word;
  logic [31:0]        pc4;
  logic [1:0]         mode;
  logic               is_j, is_beq;
  logic [31:0]        j_tgt;
  logic signed [15:0] br_imm;
  logic signed [31:0] br_off;
  logic [31:0]        beq_tgt;
  logic               ex_redir;
  logic [31:0]        redir_addr;

  fetch_imem #(.IM_DEPTH(IM_DEPTH), .AW(AW)) u_imem (
    .addr  (pc[AW+1:2]),
    .rdata (fetch_word)
  );

  assign mode    = eff_mode(bp_mode);
  assign pc4     = pc + 32'd4;
  assign is_j    = (fetch_word[31:26] == OP_J);
  assign is_beq  = (fetch_word[31:26] == OP_BEQ);
  assign j_tgt   = {pc4[31:28], fetch_word[25:0], 2'b00};
  assign br_imm  = fetch_word[15:0];
  assign br_off  = 32'(br_imm) <<< 2;
  assign beq_tgt = pc4 + $unsigned(br_off);

  // Redirect from EX: a mispredicted (or, in delay mode, taken) branch.
  always_comb begin
    ex_redir   = 1'b0;
    redir_addr = ex_br_target;
    case (mode)
      BP_TAKEN: begin
        ex_redir   = ex_br_valid & ~ex_br_taken;
        redir_addr = ex_br_pc4;
      end
      default: ex_redir = ex_br_valid & ex_br_taken;
    endcase
  end

  assign id_flush = ex_redir & (bp_mode != BP_DELAY);

  // Next-state / next-PC selection: redirect > stall > predecode > PC+4.
  always_comb begin
    state_nxt = state;
    jtgt_nxt  = jtgt;
    pc_nxt    = pc;
    ir_nxt    = if_ir;
    ifpc4_nxt = if_pc4;
    if (ex_redir) begin
      pc_nxt    = redir_addr;
      ir_nxt    = NOP_WORD;
      ifpc4_nxt = pc4;
      state_nxt = ST_RUN;
    end else if (!stall) begin
      ir_nxt    = fetch_word;
      ifpc4_nxt = pc4;
      case (state)
        ST_RUN: begin
          if (is_j && mode != BP_DELAY) begin
            pc_nxt = j_tgt;
          end else if (is_j) begin
            pc_nxt    = pc4;
            jtgt_nxt  = j_tgt;
            state_nxt = ST_JPEND;
          end else if (is_beq && mode == BP_TAKEN) begin
            pc_nxt = beq_tgt;
          end else begin
            pc_nxt = pc4;
          end
        end
        ST_JPEND: begin
          pc_nxt    = jtgt;
          state_nxt = ST_RUN;
        end
        default: begin
          pc_nxt    = pc4;
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // PC, IF/ID register and FSM state update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      if_ir  <= NOP_WORD;
      if_pc4 <= 32'h0;
      state  <= ST_RUN;
      jtgt   <= 32'h0;
    end else begin
      pc     <= pc_nxt;
      if_ir  <= ir_nxt;
      if_pc4 <= ifpc4_nxt;
      state  <= state_nxt;
      jtgt   <= jtgt_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Saturating event counters: fetching, redirected and stalled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch <= 32'h0;
      perf_redir <= 32'h0;
      perf_stall <= 32'h0;
    end else begin
      if (ex_redir)       perf_redir <= sat_inc(perf_redir);
      if (stall && !ex_redir) perf_stall <= sat_inc(perf_stall);
      else                perf_fetch <= sat_inc(perf_fetch);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage_bp.sv
// Directed bench for fetch_stage_bp: sequential fetch, redirects in each
// branch mode, delay-slot jumps, stall interaction and mid-cycle reset.
`timescale 1ns/1ps
module tb_fetch_stage_bp;

  logic        clk;
  logic        rst;
  logic [1:0]  bp_mode;
  logic        stall;
  logic        ex_br_valid;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic [31:0] ex_br_pc4;
  logic [31:0] pc;
  logic [31:0] if_ir;
  logic [31:0] if_pc4;
  logic        id_flush;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W_ADDI0 = 32'h2001_0001;
  localparam logic [31:0] W_ADDI1 = 32'h2001_0002;
  localparam logic [31:0] W_ADDI2 = 32'h2001_0003;
  localparam logic [31:0] W_BEQ   = 32'h1022_0003; // beq imm=3 at 0x10
  localparam logic [31:0] W_J     = 32'h0800_0006; // j imm26=6 at 0x48
  localparam logic [31:0] W_SLOT  = 32'h2002_000A; // delay slot at 0x4C
  localparam logic [31:0] W_L2    = 32'h2003_0007; // loop2 at 0x18

  fetch_stage_bp #(.IM_DEPTH(64), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .bp_mode      (bp_mode),
    .stall        (stall),
    .ex_br_valid  (ex_br_valid),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .ex_br_pc4    (ex_br_pc4),
    .pc           (pc),
    .if_ir        (if_ir),
    .if_pc4       (if_pc4),
    .id_flush     (id_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (if_ir !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=%h", if_ir, 32'h0); end
    checks++; if (if_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", if_pc4, 32'h0); end
    checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", id_flush); end
  endtask

  task automatic test_sequential();
    rst = 1'b1;
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 32'h4); end
    checks++; if (if_ir !== W_ADDI0) begin errors++; $display("FAIL seq_ir1 got=%h exp=%h", if_ir, W_ADDI0); end
    checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL seq_pc4_1 got=%h exp=%h", if_pc4, 32'h4); end
    step();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc2 got=%h exp=%h", pc, 32'h8); end
    checks++; if (if_ir !== W_ADDI1) begin errors++; $display("FAIL seq_ir2 got=%h exp=%h", if_ir, W_ADDI1); end
    step();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_pc3 got=%h exp=%h", pc, 32'hC); end
    checks++; if (if_ir !== W_ADDI2) begin errors++; $display("FAIL seq_ir3 got=%h exp=%h", if_ir, W_ADDI2); end
  endtask

  task automatic test_not_taken_mode();
    bp_mode = 2'b00;
    ex_br_valid = 1'b1; ex_br_taken = 1'b0; ex_br_target = 32'h40; ex_br_pc4 = 32'h8;
    #1;
    checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL nt_untaken_flush got=%b exp=0", id_flush); end
    step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL nt_untaken_pc got=%h exp=%h", pc, 32'h10); end
    ex_br_taken = 1'b1;
    #1;
    checks++; if (id_flush !== 1'b1) begin errors++; $display("FAIL nt_taken_flush got=%b exp=1", id_flush); end
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL nt_taken_pc got=%h exp=%h", pc, 32'h40); end
    checks++; if (if_ir !== 32'h0) begin errors++; $display("FAIL nt_taken_ir got=%h exp=%h", if_ir, 32'h0); end
    ex_br_valid = 1'b0;
    #1;
    checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL nt_idle_flush got=%b exp=0", id_flush); end
    // reserved mode 11 behaves as not-taken
    bp_mode = 2'b11;
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h10;
    #1;
    checks++; if (id_flush !== 1'b1) begin errors++; $display("FAIL m11_flush got=%b exp=1", id_flush); end
    step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL m11_pc got=%h exp=%h", pc, 32'h10); end
    ex_br_valid = 1'b0;
  endtask

  task automatic test_taken_mode();
    bp_mode = 2'b01;
    step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL tk_beq_pc got=%h exp=%h", pc, 32'h20); end
    checks++; if (if_ir !== W_BEQ) begin errors++; $display("FAIL tk_beq_ir got=%h exp=%h", if_ir, W_BEQ); end
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h20; ex_br_pc4 = 32'h14;
    #1;
    checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL tk_correct_flush got=%b exp=0", id_flush); end
    ex_br_taken = 1'b0;
    #1;
    checks++; if (id_flush !== 1'b1) begin errors++; $display("FAIL tk_wrong_flush got=%b exp=1", id_flush); end
    step();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL tk_recover_pc got=%h exp=%h", pc, 32'h14); end
    checks++; if (if_ir !== 32'h0) begin errors++; $display("FAIL tk_recover_ir got=%h exp=%h", if_ir, 32'h0); end
    ex_br_valid = 1'b0;
  endtask

  task automatic test_delay_slot();
    bp_mode = 2'b10;
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h48;
    #1;
    checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL ds_redir_flush got=%b exp=0", id_flush); end
    step();
    checks++; if (pc !== 32'h48) begin errors++; $display("FAIL ds_redir_pc got=%h exp=%h", pc, 32'h48); end
    ex_br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h4C) begin errors++; $display("FAIL ds_slot_pc got=%h exp=%h", pc, 32'h4C); end
    checks++; if (if_ir !== W_J) begin errors++; $display("FAIL ds_j_ir got=%h exp=%h", if_ir, W_J); end
    step();
    checks++; if (pc !== 32'h18) begin errors++; $display("FAIL ds_jump_pc got=%h exp=%h", pc, 32'h18); end
    checks++; if (if_ir !== W_SLOT) begin errors++; $display("FAIL ds_slot_ir got=%h exp=%h", if_ir, W_SLOT); end
    checks++; if (if_pc4 !== 32'h50) begin errors++; $display("FAIL ds_slot_pc4 got=%h exp=%h", if_pc4, 32'h50); end
    step();
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL ds_after_pc got=%h exp=%h", pc, 32'h1C); end
  endtask

  task automatic test_stall_redirect();
    bp_mode = 2'b00;
    stall = 1'b1;
    step();
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL st_hold_pc got=%h exp=%h", pc, 32'h1C); end
    checks++; if (if_ir !== W_L2) begin errors++; $display("FAIL st_hold_ir got=%h exp=%h", if_ir, W_L2); end
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h60;
    #1;
    checks++; if (id_flush !== 1'b1) begin errors++; $display("FAIL st_redir_flush got=%b exp=1", id_flush); end
    step();
    checks++; if (pc !== 32'h60) begin errors++; $display("FAIL st_redir_pc got=%h exp=%h", pc, 32'h60); end
    checks++; if (if_ir !== 32'h0) begin errors++; $display("FAIL st_redir_ir got=%h exp=%h", if_ir, 32'h0); end
    ex_br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h60) begin errors++; $display("FAIL st_hold2_pc got=%h exp=%h", pc, 32'h60); end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h64) begin errors++; $display("FAIL st_release_pc got=%h exp=%h", pc, 32'h64); end
  endtask

  task automatic test_reset_in_jpend();
    bp_mode = 2'b10;
    ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h48;
    step();
    ex_br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h4C) begin errors++; $display("FAIL rj_setup_pc got=%h exp=%h", pc, 32'h4C); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rj_async_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (if_ir !== 32'h0) begin errors++; $display("FAIL rj_async_ir got=%h exp=%h", if_ir, 32'h0); end
    #1;
    rst = 1'b1;
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rj_after1_pc got=%h exp=%h", pc, 32'h4); end
    checks++; if (if_ir !== W_ADDI0) begin errors++; $display("FAIL rj_after1_ir got=%h exp=%h", if_ir, W_ADDI0); end
    step();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL rj_after2_pc got=%h exp=%h", pc, 32'h8); end
  endtask

  initial begin
    rst = 1'b0; bp_mode = 2'b00; stall = 1'b0;
    ex_br_valid = 1'b0; ex_br_taken = 1'b0; ex_br_target = 32'h0; ex_br_pc4 = 32'h0;
    for (int i = 0; i < 64; i++) dut.u_imem.memory[i] = 32'h0;
    dut.u_imem.memory[0]  = W_ADDI0;
    dut.u_imem.memory[1]  = W_ADDI1;
    dut.u_imem.memory[2]  = W_ADDI2;
    dut.u_imem.memory[4]  = W_BEQ;
    dut.u_imem.memory[6]  = W_L2;
    dut.u_imem.memory[18] = W_J;
    dut.u_imem.memory[19] = W_SLOT;

    test_reset();
    test_sequential();
    test_not_taken_mode();
    test_taken_mode();
    test_delay_slot();
    test_stall_redirect();
    test_reset_in_jpend();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
